instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have a parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of the first word written.
REQ-002 The block SHALL have a parameter DEPTH, default 64, giving the maximum number of words per program load (range 1-256).
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high. Port names SHALL be clk and reset.
REQ-004 Ports SHALL be as follows (direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin a program load
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- in_kind  in  3  0=lw 1=sw 2=R-type 3=addi 4=beq 5=j; 6-7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_shamt  in  5  shift amount
- in_funct  in  6  R-type function field
- in_imm  in  16  immediate or branch offset
- in_target  in  26  jump target
- in_last  in  1  final instruction of the program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  32  byte address of the write
- imem_wdata  out  32  encoded instruction word
- count  out  9  words written in the current load
- done  out  1  load complete
- err  out  1  sticky flag for an illegal in_kind

Function
REQ-005 The FSM SHALL have four states: IDLE, ACCEPT, WRITE and DONE.
REQ-006 IDLE: in_ready=0; start=1 SHALL move to ACCEPT, clear count and err, and set the address pointer to BASE_ADDR.
REQ-007 ACCEPT: in_ready=1; a handshake occurs when in_valid&in_ready are both 1.
REQ-008 On a legal-kind handshake, the encoded word SHALL be registered and the FSM SHALL move to WRITE.
REQ-009 Encoding (fields MSB to LSB):
- lw: 100011|rs|rt|imm
- sw: 101011|rs|rt|imm
- R-type: 000000|rs|rt|rd|shamt|funct
- addi: 001000|rs|rt|imm
- beq: 000100|rs|rt|imm
- j: 000010|target
- Unused input fields SHALL be ignored.
REQ-010 On an illegal-kind handshake, err SHALL set, no write SHALL occur, and the FSM SHALL remain in ACCEPT, or go to DONE if in_last=1.
REQ-011 WRITE SHALL last exactly one cycle, with imem_we=1, imem_addr=pointer and imem_wdata=registered word.
REQ-012 At the end of WRITE, the pointer SHALL advance by 4 and count by 1.
REQ-013 After WRITE, the next state SHALL be DONE if the accepted in_last=1 or the new count equals DEPTH; otherwise ACCEPT.
REQ-014 Latency SHALL be: a handshake in cycle N gives imem_we in cycle N+1. Maximum throughput is one word per 2 cycles; in_ready=0 in WRITE.
REQ-015 DONE: done=1 and in_ready=0, held until start=1, which SHALL begin a new load exactly as from IDLE.
REQ-016 start SHALL be ignored in ACCEPT and WRITE.
REQ-017 Once count=DEPTH the load is full: no further writes occur, and the pointer SHALL NOT wrap.
REQ-018 imem_wdata and imem_addr SHALL hold their last values when imem_we=0.

Reset
REQ-019 While reset=1, on the clock edge: state=IDLE, in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, err=0.
REQ-020 Reset SHALL take priority over all inputs. Reset asserted during WRITE SHALL suppress that write from the next cycle onward, and the pending word SHALL be discarded.

Verification
REQ-021 The bench SHALL cover: start, then lw rs=2 rt=3 imm=0x0010 with in_last=1 -> one write: addr 0x0, data 0x8C430010; done=1; count=1.
REQ-022 The bench SHALL cover: sequence R-type (rs=1 rt=2 rd=3 shamt=0 funct=0x20), addi (rs=0 rt=8 imm=5), beq (rs=4 rt=5 imm=0xFFFF), j (target=0x10, last) -> writes:
- 0x0: 0x00221820
- 0x4: 0x20080005
- 0x8: 0x1085FFFF
- 0xC: 0x08000010
- then count=4 and done=1.
REQ-023 The bench SHALL cover: in_kind=7 mid-sequence -> err=1, no write, and the next legal word lands at the following consecutive address.
REQ-024 The bench SHALL cover: DEPTH=2 with 3 words offered -> 2 writes, done=1, and in_ready=0 for the third word.
REQ-025 The bench SHALL cover: reset asserted in the WRITE cycle of the second word -> imem_we=0 from the next cycle, state=IDLE, count=0; a new start then writes at BASE_ADDR.
REQ-026 The bench SHALL cover: in_valid held high continuously -> in_ready alternates 1/0 and imem_we pulses every second cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded MIPS-style instruction fields over a
// valid/ready handshake, packs them into 32-bit words and writes them to
// consecutive instruction-memory byte addresses starting at BASE_ADDR.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [5:0]  in_funct,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [8:0]  count,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  localparam logic [2:0] K_LW   = 3'd0;
  localparam logic [2:0] K_SW   = 3'd1;
  localparam logic [2:0] K_R    = 3'd2;
  localparam logic [2:0] K_ADDI = 3'd3;
  localparam logic [2:0] K_BEQ  = 3'd4;
  localparam logic [2:0] K_J    = 3'd5;

  state_t      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;      // address the next accepted word will use
  logic [8:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;    // write address, held between writes
  logic [31:0] wdata_q, wdata_d;  // encoded word, held between writes
  logic        last_q, last_d;    // in_last captured with the pending word

  logic [31:0] enc_word;
  logic        kind_legal;
  logic [8:0]  count_inc;

  // Pack the instruction fields for the current kind; fields not used by
  // that kind never reach the word.
  always_comb begin
    enc_word   = 32'h0;
    kind_legal = 1'b1;
    case (in_kind)
      K_LW:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      K_SW:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      K_R:     enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      K_ADDI:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
      K_BEQ:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
      K_J:     enc_word = {6'b000010, in_target};
      default: kind_legal = 1'b0;
    endcase
  end

  assign count_inc = count_q + 9'd1;

  // Next-state logic: load start, handshake capture and write bookkeeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCEPT;
          ptr_d   = BASE_ADDR;
          count_d = 9'd0;
          err_d   = 1'b0;
        end
      end
      ACCEPT: begin
        if (in_valid) begin
          if (kind_legal) begin
            wdata_d = enc_word;
            addr_d  = ptr_q;
            last_d  = in_last;
            state_d = WRITE;
          end else begin
            // Illegal kinds are dropped but still honour in_last.
            err_d = 1'b1;
            if (in_last) begin
              state_d = DONE;
            end
          end
        end
      end
      WRITE: begin
        ptr_d   = ptr_q + 32'd4;
        count_d = count_inc;
        // Reaching DEPTH ends the load so the pointer never runs past it.
        if (last_q || (count_inc == DEPTH_C)) begin
          state_d = DONE;
        end else begin
          state_d = ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything, which also
  // drops a word whose write cycle is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      count_q <= 9'd0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == ACCEPT);
  assign imem_we    = (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected {addr,data}
// writes into a queue per instance, monitors pop and compare on each write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic        in_valid;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        in_ready, imem_we, done, err;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  count;

  logic        in_ready2, imem_we2, done2, err2;
  logic [31:0] imem_addr2, imem_wdata2;
  logic [8:0]  count2;

  int checks = 0;
  int errors = 0;

  logic [63:0] q1[$];
  logic [63:0] q2[$];

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_1000), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid),
    .in_ready(in_ready2), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .count(count2), .done(done2), .err(err2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor for the DEPTH=64 instance.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_write", {imem_addr, imem_wdata}, 64'h0);
      end else begin
        chk("write", {imem_addr, imem_wdata}, q1.pop_front());
      end
    end
  end

  // Monitor for the DEPTH=2 instance.
  always @(negedge clk) begin
    if (imem_we2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_write2", {imem_addr2, imem_wdata2}, 64'h0);
      end else begin
        chk("write2", {imem_addr2, imem_wdata2}, q2.pop_front());
      end
    end
  end

  task automatic set_fields(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tg, input logic last);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  // Offer the current fields and return one cycle after the handshake edge.
  task automatic handshake(input int sel);
    int n;
    n = 0;
    in_valid = 1'b1;
    while (((sel == 0) ? in_ready : in_ready2) !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      chk("handshake_timeout", 64'd1, 64'd0);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int sel);
    if (sel == 0) start = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? done : done2) !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10) chk("done_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr2", imem_addr2, 32'h1000);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);

    // Single lw, last.
    do_start(0);
    chk("accept_in_ready", in_ready, 1);
    q1.push_back({32'h0, 32'h8C430010});
    set_fields(3'd0, 5'd2, 5'd3, 5'd31, 5'd31, 6'h3F, 16'h0010, 26'h3FFFFFF, 1'b1);
    handshake(0);
    chk("write_in_ready", in_ready, 0);
    wait_done(0);
    chk("t1_done", done, 1);
    chk("t1_count", count, 1);
    chk("t1_err", err, 0);

    // Four-word program with junk in unused fields.
    do_start(0);
    chk("restart_count", count, 0);
    q1.push_back({32'h0, 32'h00221820});
    set_fields(3'd2, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF, 26'h1234567, 1'b0);
    handshake(0);
    q1.push_back({32'h4, 32'h20080005});
    set_fields(3'd3, 5'd0, 5'd8, 5'd31, 5'd7, 6'h15, 16'h0005, 26'h2AAAAAA, 1'b0);
    handshake(0);
    q1.push_back({32'h8, 32'h1085FFFF});
    set_fields(3'd4, 5'd4, 5'd5, 5'd9, 5'd9, 6'h01, 16'hFFFF, 26'h0, 1'b0);
    handshake(0);
    q1.push_back({32'hC, 32'h08000010});
    set_fields(3'd5, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010, 1'b1);
    handshake(0);
    wait_done(0);
    chk("t2_done", done, 1);
    chk("t2_count", count, 4);
    chk("t2_hold_addr", imem_addr, 32'hC);
    chk("t2_hold_wdata", imem_wdata, 32'h08000010);

    // Illegal kind mid-sequence.
    do_start(0);
    q1.push_back({32'h0, 32'h8C430010});
    set_fields(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    handshake(0);
    set_fields(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1111, 26'd1, 1'b0);
    @(posedge clk); #1;
    handshake(0);
    chk("t3_err", err, 1);
    chk("t3_stay_accept", in_ready, 1);
    q1.push_back({32'h4, 32'hAC220004});
    set_fields(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    handshake(0);
    wait_done(0);
    chk("t3_count", count, 2);
    chk("t3_err_sticky", err, 1);

    // DEPTH=2 instance with three words offered.
    do_start(1);
    q2.push_back({32'h1000, 32'h20080005});
    set_fields(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
    handshake(1);
    q2.push_back({32'h1004, 32'h1085FFFF});
    set_fields(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    handshake(1);
    wait_done(1);
    chk("t4_done2", done2, 1);
    chk("t4_count2", count2, 2);
    set_fields(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t4_third_ready2", in_ready2, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t4_count2_after", count2, 2);

    // Reset during the WRITE cycle of the second word.
    do_start(0);
    q1.push_back({32'h0, 32'h8C430010});
    set_fields(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    handshake(0);
    q1.push_back({32'h4, 32'h20080005});
    set_fields(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
    handshake(0);
    chk("t5_in_write", imem_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_we_off", imem_we, 0);
    chk("t5_count", count, 0);
    chk("t5_idle_ready", in_ready, 0);
    chk("t5_idle_done", done, 0);
    @(posedge clk); #1;
    chk("t5_still_idle", in_ready, 0);
    do_start(0);
    q1.push_back({32'h0, 32'h1085FFFF});
    set_fields(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1);
    handshake(0);
    wait_done(0);
    chk("t5_count_new", count, 1);

    // in_valid held high: ready/we alternate.
    do_start(0);
    q1.push_back({32'h0, 32'h8C430010});
    q1.push_back({32'h4, 32'h20080005});
    q1.push_back({32'h8, 32'h1085FFFF});
    q1.push_back({32'hC, 32'h08000010});
    set_fields(3'd0, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t6_ready", in_ready, ((i % 2) == 0) ? 64'd1 : 64'd0);
      chk("t6_we", imem_we, ((i % 2) == 1) ? 64'd1 : 64'd0);
      if (i == 1) set_fields(3'd3, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
      if (i == 3) set_fields(3'd4, 5'd4, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
      if (i == 5) set_fields(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0000010, 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("t6_done", done, 1);
    chk("t6_count", count, 4);

    repeat (2) @(posedge clk);
    #1;
    chk("sb1_empty", q1.size(), 0);
    chk("sb2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
